// File: rtl/line_buffer_ctrl.sv
// Line buffer controller for a 3-row vertical window.
// Incoming raster pixels are written into a two-bank line RAM (bank = row[0]).
// Once two rows are primed, each accepted pixel reads row-1 (port A, other
// bank) and row-2 (port B, same slot being overwritten, read-before-write)
// and emits a (top, mid, bot) column one cycle later.
module line_buffer_ctrl #(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 8,
  parameter int FRAME_H_P = 8,
  parameter int AW        = $clog2(2*LINE_W_P)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH_P-1:0] pix_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [WIDTH_P-1:0] ram_data_o,
  output logic [AW-1:0]      ram_wr_addr_o,
  output logic               ram_wr_en_o,
  output logic [AW-1:0]      ram_rd_addr_a_o,
  output logic [AW-1:0]      ram_rd_addr_b_o,
  output logic               ram_rd_en_a_o,
  output logic               ram_rd_en_b_o,
  input  logic [WIDTH_P-1:0] ram_data_a_i,
  input  logic [WIDTH_P-1:0] ram_data_b_i,
  output logic [WIDTH_P-1:0] top_o,
  output logic [WIDTH_P-1:0] mid_o,
  output logic [WIDTH_P-1:0] bot_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               eol_o,
  output logic               eof_o
);

  localparam int CW = (LINE_W_P  > 1) ? $clog2(LINE_W_P)  : 1;
  localparam int RW = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1;

  typedef enum logic [1:0] {PRIME0, PRIME1, STREAM} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [WIDTH_P-1:0] bot_q;
  logic               accept, last_col, last_row;

  function automatic logic [AW-1:0] slot(input logic bank, input logic [CW-1:0] c);
    return (bank ? AW'(LINE_W_P) : AW'(0)) + AW'(c);
  endfunction

  // An output register may take a new column whenever its current one leaves.
  assign ready_o  = !valid_o || ready_i;
  assign accept   = valid_i && ready_o && !rst_i;
  assign last_col = (col == CW'(LINE_W_P-1));
  assign last_row = (row == RW'(FRAME_H_P-1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= PRIME0;
    else       state <= state_n;
  end

  // Next state: advance priming per completed row, return to PRIME0 at frame end
  always_comb begin
    state_n = state;
    if (accept && last_col) begin
      case (state)
        PRIME0:  state_n = PRIME1;
        PRIME1:  state_n = STREAM;
        STREAM:  if (last_row) state_n = PRIME0;
        default: state_n = PRIME0;
      endcase
    end
  end

  // RAM control: write every accepted pixel, read both older rows only while streaming
  always_comb begin
    ram_wr_en_o     = accept;
    ram_wr_addr_o   = slot(row[0], col);
    ram_data_o      = pix_i;
    ram_rd_en_a_o   = accept && (state == STREAM);
    ram_rd_en_b_o   = accept && (state == STREAM);
    ram_rd_addr_a_o = slot(!row[0], col);
    ram_rd_addr_b_o = slot(row[0], col);
  end

  // Raster position counters and the registered output column
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col     <= '0;
      row     <= '0;
      valid_o <= 1'b0;
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;
      bot_q   <= '0;
    end else begin
      if (accept) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) row <= last_row ? '0 : row + 1'b1;
      end
      if (accept && state == STREAM) begin
        valid_o <= 1'b1;
        bot_q   <= pix_i;
        eol_o   <= last_col;
        eof_o   <= last_col && last_row;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  // RAM outputs hold while reads are idle, and reads only occur when the
  // pending column is consumed, so they can drive top/mid directly.
  assign top_o = valid_o ? ram_data_b_i : '0;
  assign mid_o = valid_o ? ram_data_a_i : '0;
  assign bot_o = bot_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a behavioural 1W/2R line RAM.
module tb_line_buffer_ctrl;
  localparam int W = 8, LW = 4, FH = 4, AW = 3;

  logic          clk_i = 1'b0, rst_i = 1'b1;
  logic [W-1:0]  pix_i = '0;
  logic          valid_i = 1'b0, ready_i = 1'b1;
  logic          ready_o, ram_wr_en_o, ram_rd_en_a_o, ram_rd_en_b_o;
  logic [W-1:0]  ram_data_o, ram_data_a_i, ram_data_b_i, top_o, mid_o, bot_o;
  logic [AW-1:0] ram_wr_addr_o, ram_rd_addr_a_o, ram_rd_addr_b_o;
  logic          valid_o, eol_o, eof_o;

  int errors = 0, checks = 0;

  line_buffer_ctrl #(.WIDTH_P(W), .LINE_W_P(LW), .FRAME_H_P(FH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pix_i(pix_i), .valid_i(valid_i), .ready_o(ready_o),
    .ram_data_o(ram_data_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_en_o(ram_wr_en_o),
    .ram_rd_addr_a_o(ram_rd_addr_a_o), .ram_rd_addr_b_o(ram_rd_addr_b_o),
    .ram_rd_en_a_o(ram_rd_en_a_o), .ram_rd_en_b_o(ram_rd_en_b_o),
    .ram_data_a_i(ram_data_a_i), .ram_data_b_i(ram_data_b_i),
    .top_o(top_o), .mid_o(mid_o), .bot_o(bot_o), .valid_o(valid_o), .ready_i(ready_i),
    .eol_o(eol_o), .eof_o(eof_o)
  );

  always #5 clk_i = ~clk_i;

  // Line RAM: read-before-write, outputs hold while read enable is low
  logic [W-1:0] mem [2*LW];
  logic [W-1:0] q_a = '0, q_b = '0;
  always @(posedge clk_i) begin
    if (ram_rd_en_a_o) q_a <= mem[ram_rd_addr_a_o];
    if (ram_rd_en_b_o) q_b <= mem[ram_rd_addr_b_o];
    if (ram_wr_en_o)   mem[ram_wr_addr_o] <= ram_data_o;
  end
  assign ram_data_a_i = q_a;
  assign ram_data_b_i = q_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Column produced by pixel p of a 4x4 frame numbered 1..16
  task automatic chk_col(input int p);
    chk($sformatf("col%0d_valid", p), 32'(valid_o), 1);
    chk($sformatf("col%0d_top", p), 32'(top_o), 32'(p-8));
    chk($sformatf("col%0d_mid", p), 32'(mid_o), 32'(p-4));
    chk($sformatf("col%0d_bot", p), 32'(bot_o), 32'(p));
    chk($sformatf("col%0d_eol", p), 32'(eol_o), 32'(((p-1) % 4) == 3));
    chk($sformatf("col%0d_eof", p), 32'(eof_o), 32'(p == 16));
  endtask

  // Full frame of pixels 1..16 with no backpressure, checking RAM traffic and columns
  task automatic run_frame(input string tag);
    int idx, r, c;
    for (int p = 1; p <= 16; p++) begin
      if (p >= 10) chk_col(p-1);
      else chk($sformatf("%s_noval%0d", tag, p), 32'(valid_o), 0);
      if (p == 9)
        for (int i = 0; i < 8; i++) chk($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(i+1));
      idx = p - 1; r = idx / 4; c = idx % 4;
      valid_i = 1'b1; pix_i = W'(p); ready_i = 1'b1;
      #1;
      chk($sformatf("%s_wen%0d", tag, p), 32'(ram_wr_en_o), 1);
      chk($sformatf("%s_waddr%0d", tag, p), 32'(ram_wr_addr_o), 32'((r % 2) * 4 + c));
      chk($sformatf("%s_rena%0d", tag, p), 32'(ram_rd_en_a_o), 32'(p >= 9));
      chk($sformatf("%s_renb%0d", tag, p), 32'(ram_rd_en_b_o), 32'(p >= 9));
      if (p >= 9) begin
        chk($sformatf("%s_raddra%0d", tag, p), 32'(ram_rd_addr_a_o), 32'(((r + 1) % 2) * 4 + c));
        chk($sformatf("%s_raddrb%0d", tag, p), 32'(ram_rd_addr_b_o), 32'((r % 2) * 4 + c));
      end
      tick();
    end
    chk_col(16);
    valid_i = 1'b0;
    #1;
    chk($sformatf("%s_idle_ren", tag), 32'(ram_rd_en_a_o), 0);
    tick();
    chk($sformatf("%s_drained", tag), 32'(valid_o), 0);
  endtask

  task automatic push(input int p);
    valid_i = 1'b1; pix_i = W'(p); tick(); valid_i = 1'b0;
  endtask

  initial begin
    // Reset with a pixel offered: nothing may be written or emitted
    rst_i = 1'b1; valid_i = 1'b1; pix_i = 8'hAA; ready_i = 1'b1;
    tick(); tick();
    chk("rst_wen", 32'(ram_wr_en_o), 0);
    chk("rst_rena", 32'(ram_rd_en_a_o), 0);
    chk("rst_renb", 32'(ram_rd_en_b_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_eol", 32'(eol_o), 0);
    chk("rst_eof", 32'(eof_o), 0);
    chk("rst_top", 32'(top_o), 0);
    chk("rst_mid", 32'(mid_o), 0);
    chk("rst_bot", 32'(bot_o), 0);
    rst_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 1);
    tick();

    // Prime, stream and frame end
    run_frame("f1");

    // Next frame re-primes: 8 pixels, no columns, writes restart at address 0
    for (int p = 17; p <= 24; p++) begin
      valid_i = 1'b1; pix_i = W'(p);
      #1;
      chk($sformatf("reprime_waddr%0d", p), 32'(ram_wr_addr_o), 32'(p-17));
      chk($sformatf("reprime_ren%0d", p), 32'(ram_rd_en_a_o), 0);
      tick();
      chk($sformatf("reprime_noval%0d", p), 32'(valid_o), 0);
    end
    valid_i = 1'b0;

    // Backpressure during row 2
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int p = 1; p <= 9; p++) push(p);
    ready_i = 1'b0; valid_i = 1'b1; pix_i = 8'd10;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready%0d", k), 32'(ready_o), 0);
      chk($sformatf("bp_wen%0d", k), 32'(ram_wr_en_o), 0);
      chk($sformatf("bp_rena%0d", k), 32'(ram_rd_en_a_o), 0);
      chk($sformatf("bp_renb%0d", k), 32'(ram_rd_en_b_o), 0);
      chk_col(9);
      tick();
    end
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_o), 1);
    chk("bp_release_wen", 32'(ram_wr_en_o), 1);
    tick();
    chk_col(10);
    pix_i = 8'd11; tick();
    chk_col(11);
    pix_i = 8'd12; tick();
    chk_col(12);
    valid_i = 1'b0; tick();
    chk("bp_drained", 32'(valid_o), 0);

    // Reset mid-frame with a column pending, then a clean frame
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int p = 1; p <= 10; p++) push(p);
    chk("mid_pending", 32'(valid_o), 1);
    ready_i = 1'b0; rst_i = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_ready", 32'(ready_o), 1);
    rst_i = 1'b0; ready_i = 1'b1;
    run_frame("f2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
